// File: rtl/larpix_piso_rx.sv
`default_nettype none
// ============================================================================
//  Module      : larpix_piso_rx
//  Description : LArPix PISO-line receiver. Synchronizes and oversamples the
//                idle-high serial line, deframes start/data/stop words,
//                checks odd parity, and presents packets on valid/ready.
//                Saturating diagnostic counters for frame, parity and
//                overflow errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module larpix_piso_rx #(
    parameter int WIDTH        = 64,
    parameter int CLKS_PER_BIT = 4,
    parameter int CNT_BITS     = 16
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                piso,
    output logic [WIDTH-1:0]    rx_data,
    output logic                rx_valid,
    input  logic                rx_ready,
    output logic                rx_parity_err,
    output logic                rx_busy,
    input  logic                clear_counts,
    output logic [CNT_BITS-1:0] frame_err_cnt,
    output logic [CNT_BITS-1:0] parity_err_cnt,
    output logic [CNT_BITS-1:0] overflow_cnt
);

    localparam int C_SCNT_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int C_IDX_W  = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    // Start-bit centre is half a bit after t0; later samples are one bit apart.
    localparam logic [C_SCNT_W-1:0] C_HALF_LAST = C_SCNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [C_SCNT_W-1:0] C_BIT_LAST  = C_SCNT_W'(CLKS_PER_BIT - 1);
    localparam logic [C_IDX_W-1:0]  C_IDX_LAST  = C_IDX_W'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    logic [1:0]          sync_q;
    logic                rxs;
    state_t              state_q;
    logic [C_SCNT_W-1:0] scnt_q;
    logic [C_IDX_W-1:0]  bidx_q;
    logic [WIDTH-1:0]    shreg_q;

    logic [WIDTH-1:0]    rx_data_q;
    logic                rx_valid_q;
    logic                rx_parity_err_q;
    logic [CNT_BITS-1:0] frame_err_cnt_q,  frame_err_cnt_d;
    logic [CNT_BITS-1:0] parity_err_cnt_q, parity_err_cnt_d;
    logic [CNT_BITS-1:0] overflow_cnt_q,   overflow_cnt_d;

    logic stop_sample;
    logic frame_good;
    logic frame_bad;
    logic take;
    logic load;
    logic drop;
    logic parity_bad;

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], piso};
        end
    end

    assign rxs = sync_q[1];

    // Deframing FSM: start detect, centre-sampled data bits, stop check, break wait.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            scnt_q  <= '0;
            bidx_q  <= '0;
            shreg_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (!rxs) begin
                        state_q <= S_START;
                        scnt_q  <= '0;
                    end
                end
                S_START: begin
                    if (scnt_q == C_HALF_LAST) begin
                        scnt_q  <= '0;
                        bidx_q  <= '0;
                        state_q <= rxs ? S_IDLE : S_DATA;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                S_DATA: begin
                    if (scnt_q == C_BIT_LAST) begin
                        scnt_q  <= '0;
                        shreg_q <= {rxs, shreg_q[WIDTH-1:1]};
                        if (bidx_q == C_IDX_LAST) begin
                            state_q <= S_STOP;
                        end else begin
                            bidx_q <= bidx_q + 1'b1;
                        end
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                S_STOP: begin
                    if (scnt_q == C_BIT_LAST) begin
                        scnt_q  <= '0;
                        state_q <= rxs ? S_IDLE : S_BREAK;
                    end else begin
                        scnt_q <= scnt_q + 1'b1;
                    end
                end
                S_BREAK: begin
                    if (rxs) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Frame outcome is decided on the stop-bit sample cycle.
    assign stop_sample = (state_q == S_STOP) && (scnt_q == C_BIT_LAST);
    assign frame_good  = stop_sample && rxs;
    assign frame_bad   = stop_sample && !rxs;
    assign parity_bad  = ~(^shreg_q);
    assign take        = rx_valid_q && rx_ready;
    assign load        = frame_good && (!rx_valid_q || take);
    assign drop        = frame_good && !load;

    // Output holding register: loads when free or draining, else keeps the held packet.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_q       <= '0;
            rx_valid_q      <= 1'b0;
            rx_parity_err_q <= 1'b0;
        end else if (load) begin
            rx_data_q       <= shreg_q;
            rx_parity_err_q <= parity_bad;
            rx_valid_q      <= 1'b1;
        end else if (take) begin
            rx_valid_q <= 1'b0;
        end
    end

    // Saturating increment; a simultaneous clear takes priority.
    function automatic logic [CNT_BITS-1:0] cnt_next(
        input logic [CNT_BITS-1:0] cnt,
        input logic                inc,
        input logic                clr
    );
        if (clr) begin
            return '0;
        end
        if (inc && (cnt != {CNT_BITS{1'b1}})) begin
            return cnt + CNT_BITS'(1);
        end
        return cnt;
    endfunction

    // Next-state values of the diagnostic counters.
    always_comb begin
        frame_err_cnt_d  = cnt_next(frame_err_cnt_q,  frame_bad,          clear_counts);
        parity_err_cnt_d = cnt_next(parity_err_cnt_q, load && parity_bad, clear_counts);
        overflow_cnt_d   = cnt_next(overflow_cnt_q,   drop,               clear_counts);
    end

    // Diagnostic counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_err_cnt_q  <= '0;
            parity_err_cnt_q <= '0;
            overflow_cnt_q   <= '0;
        end else begin
            frame_err_cnt_q  <= frame_err_cnt_d;
            parity_err_cnt_q <= parity_err_cnt_d;
            overflow_cnt_q   <= overflow_cnt_d;
        end
    end

    assign rx_data        = rx_data_q;
    assign rx_valid       = rx_valid_q;
    assign rx_parity_err  = rx_parity_err_q;
    assign rx_busy        = (state_q != S_IDLE);
    assign frame_err_cnt  = frame_err_cnt_q;
    assign parity_err_cnt = parity_err_cnt_q;
    assign overflow_cnt   = overflow_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_larpix_piso_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_larpix_piso_rx
//  Description : Directed self-checking bench for larpix_piso_rx with
//                2-bit counters so saturation is reachable quickly.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_larpix_piso_rx;

    localparam int W  = 64;
    localparam int C  = 4;
    localparam int CB = 2;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          piso = 1'b1;
    logic          rx_ready = 1'b0;
    logic          clear_counts = 1'b0;
    logic [W-1:0]  rx_data;
    logic          rx_valid;
    logic          rx_parity_err;
    logic          rx_busy;
    logic [CB-1:0] frame_err_cnt;
    logic [CB-1:0] parity_err_cnt;
    logic [CB-1:0] overflow_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] got_q[$];
    logic         got_p[$];

    larpix_piso_rx #(.WIDTH(W), .CLKS_PER_BIT(C), .CNT_BITS(CB)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .piso           (piso),
        .rx_data        (rx_data),
        .rx_valid       (rx_valid),
        .rx_ready       (rx_ready),
        .rx_parity_err  (rx_parity_err),
        .rx_busy        (rx_busy),
        .clear_counts   (clear_counts),
        .frame_err_cnt  (frame_err_cnt),
        .parity_err_cnt (parity_err_cnt),
        .overflow_cnt   (overflow_cnt)
    );

    always #5 clk = ~clk;

    // Record every handshake, sampled mid-cycle before the accepting edge.
    always @(negedge clk) begin
        if (rx_valid && rx_ready) begin
            got_q.push_back(rx_data);
            got_p.push_back(rx_parity_err);
        end
    end

    task automatic send_bit(input logic b);
        @(posedge clk);
        #1 piso = b;
        repeat (C - 1) @(posedge clk);
    endtask

    task automatic send_frame(input logic [W-1:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < W; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_clear;
        @(posedge clk);
        #1 clear_counts = 1'b1;
        @(posedge clk);
        #1 clear_counts = 1'b0;
    endtask

    task automatic flush_log;
        got_q.delete();
        got_p.delete();
    endtask

    task automatic test_reset;
        idle(3);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", rx_valid); end
        n_checks++; if (rx_data !== '0) begin n_fail++; $display("FAIL reset_data got %h exp 0", rx_data); end
        n_checks++; if (rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL reset_perr got %b exp 0", rx_parity_err); end
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", rx_busy); end
        n_checks++; if ({frame_err_cnt, parity_err_cnt, overflow_cnt} !== '0) begin n_fail++; $display("FAIL reset_counts got %h exp 0", {frame_err_cnt, parity_err_cnt, overflow_cnt}); end
        @(posedge clk);
        #1 reset_n = 1'b1;
        idle(4);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL post_reset_busy got %b exp 0", rx_busy); end
    endtask

    task automatic test_single;
        int lat;
        lat = -1;
        rx_ready = 1'b1;
        flush_log();
        fork
            send_frame(64'h1, 1'b1);
            begin
                @(posedge clk);
                for (int k = 1; k <= 300; k++) begin
                    @(posedge clk);
                    #1;
                    if (rx_valid) begin
                        lat = k;
                        break;
                    end
                end
            end
        join
        idle(3);
        // Line drop to t0 is 2 edges, plus 263 cycles to rx_valid.
        n_checks++; if (lat != 265) begin n_fail++; $display("FAIL single_latency got %0d exp 265", lat); end
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL single_count got %0d exp 1", got_q.size()); end
        else begin
            n_checks++; if (got_q[0] !== 64'h1) begin n_fail++; $display("FAIL single_data got %h exp 1", got_q[0]); end
            n_checks++; if (got_p[0] !== 1'b0) begin n_fail++; $display("FAIL single_perr got %b exp 0", got_p[0]); end
        end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL single_valid_drop got %b exp 0", rx_valid); end
        n_checks++; if ({frame_err_cnt, parity_err_cnt, overflow_cnt} !== '0) begin n_fail++; $display("FAIL single_counts got %h exp 0", {frame_err_cnt, parity_err_cnt, overflow_cnt}); end
    endtask

    task automatic test_parity;
        rx_ready = 1'b1;
        flush_log();
        send_frame(64'h3, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL parity_count got %0d exp 1", got_q.size()); end
        else begin
            n_checks++; if (got_q[0] !== 64'h3) begin n_fail++; $display("FAIL parity_data got %h exp 3", got_q[0]); end
            n_checks++; if (got_p[0] !== 1'b1) begin n_fail++; $display("FAIL parity_flag got %b exp 1", got_p[0]); end
        end
        n_checks++; if (parity_err_cnt !== 2'd1) begin n_fail++; $display("FAIL parity_cnt got %0d exp 1", parity_err_cnt); end
        n_checks++; if (frame_err_cnt !== 2'd0) begin n_fail++; $display("FAIL parity_frame_cnt got %0d exp 0", frame_err_cnt); end
        do_clear();
        n_checks++; if (parity_err_cnt !== 2'd0) begin n_fail++; $display("FAIL parity_clear got %0d exp 0", parity_err_cnt); end
    endtask

    task automatic test_overflow;
        rx_ready = 1'b0;
        flush_log();
        send_frame(64'hF000_0000_0000_0001, 1'b1);
        send_frame(64'h0000_0000_0000_0007, 1'b1);
        send_frame(64'h8000_0000_0000_0000, 1'b1);
        idle(4);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL ovf_valid got %b exp 1", rx_valid); end
        n_checks++; if (rx_data !== 64'hF000_0000_0000_0001) begin n_fail++; $display("FAIL ovf_held_data got %h exp f000000000000001", rx_data); end
        n_checks++; if (rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL ovf_perr got %b exp 0", rx_parity_err); end
        n_checks++; if (overflow_cnt !== 2'd2) begin n_fail++; $display("FAIL ovf_cnt got %0d exp 2", overflow_cnt); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL ovf_early_accept got %0d exp 0", got_q.size()); end
        @(posedge clk);
        #1 rx_ready = 1'b1;
        @(posedge clk);
        #1 rx_ready = 1'b0;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_valid_drop got %b exp 0", rx_valid); end
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL ovf_accept_count got %0d exp 1", got_q.size()); end
        else begin
            n_checks++; if (got_q[0] !== 64'hF000_0000_0000_0001) begin n_fail++; $display("FAIL ovf_accept_data got %h exp f000000000000001", got_q[0]); end
        end
        do_clear();
    endtask

    task automatic test_frame_err;
        rx_ready = 1'b1;
        flush_log();
        send_frame(64'h1, 1'b0);
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL break_busy got %b exp 1", rx_busy); end
        n_checks++; if (frame_err_cnt !== 2'd1) begin n_fail++; $display("FAIL frame_err_cnt got %0d exp 1", frame_err_cnt); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL frame_err_delivered got %0d exp 0", got_q.size()); end
        piso = 1'b1;
        idle(6);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL break_exit got %b exp 0", rx_busy); end
        send_frame(64'h7, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL after_break_count got %0d exp 1", got_q.size()); end
        else begin
            n_checks++; if (got_q[0] !== 64'h7) begin n_fail++; $display("FAIL after_break_data got %h exp 7", got_q[0]); end
            n_checks++; if (got_p[0] !== 1'b0) begin n_fail++; $display("FAIL after_break_perr got %b exp 0", got_p[0]); end
        end
        n_checks++; if (frame_err_cnt !== 2'd1) begin n_fail++; $display("FAIL after_break_ferr got %0d exp 1", frame_err_cnt); end
        do_clear();
    endtask

    task automatic test_glitch;
        rx_ready = 1'b1;
        flush_log();
        @(posedge clk);
        #1 piso = 1'b0;
        @(posedge clk);
        #1 piso = 1'b1;
        idle(3);
        n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL glitch_start got %b exp 1", rx_busy); end
        idle(10);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy got %b exp 0", rx_busy); end
        n_checks++; if (got_q.size() != 0) begin n_fail++; $display("FAIL glitch_packet got %0d exp 0", got_q.size()); end
        n_checks++; if ({frame_err_cnt, parity_err_cnt, overflow_cnt} !== '0) begin n_fail++; $display("FAIL glitch_counts got %h exp 0", {frame_err_cnt, parity_err_cnt, overflow_cnt}); end
    endtask

    task automatic test_reset_mid;
        rx_ready = 1'b0;
        send_frame(64'h3, 1'b1);
        idle(4);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL pre_reset_valid got %b exp 1", rx_valid); end
        n_checks++; if (parity_err_cnt !== 2'd1) begin n_fail++; $display("FAIL pre_reset_pcnt got %0d exp 1", parity_err_cnt); end
        flush_log();
        fork
            send_frame(64'hFFFF_FFFF_C000_0000, 1'b1);
            begin
                @(posedge clk);
                repeat (125) @(posedge clk);
                #1;
                n_checks++; if (rx_busy !== 1'b1) begin n_fail++; $display("FAIL mid_frame_busy got %b exp 1", rx_busy); end
                reset_n = 1'b0;
                #1;
                n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy got %b exp 0", rx_busy); end
                n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset_valid got %b exp 0", rx_valid); end
                n_checks++; if (rx_data !== '0) begin n_fail++; $display("FAIL mid_reset_data got %h exp 0", rx_data); end
                n_checks++; if (rx_parity_err !== 1'b0) begin n_fail++; $display("FAIL mid_reset_perr got %b exp 0", rx_parity_err); end
                n_checks++; if (parity_err_cnt !== 2'd0) begin n_fail++; $display("FAIL mid_reset_pcnt got %0d exp 0", parity_err_cnt); end
                repeat (3) @(posedge clk);
                #1 reset_n = 1'b1;
            end
        join
        idle(10);
        n_checks++; if (rx_busy !== 1'b0) begin n_fail++; $display("FAIL post_mid_busy got %b exp 0", rx_busy); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL post_mid_valid got %b exp 0", rx_valid); end
        rx_ready = 1'b1;
        send_frame(64'h1, 1'b1);
        idle(4);
        n_checks++; if (got_q.size() != 1) begin n_fail++; $display("FAIL post_mid_count got %0d exp 1", got_q.size()); end
        else begin
            n_checks++; if (got_q[0] !== 64'h1) begin n_fail++; $display("FAIL post_mid_data got %h exp 1", got_q[0]); end
        end
        n_checks++; if ({frame_err_cnt, parity_err_cnt, overflow_cnt} !== '0) begin n_fail++; $display("FAIL post_mid_counts got %h exp 0", {frame_err_cnt, parity_err_cnt, overflow_cnt}); end
    endtask

    task automatic test_saturation;
        rx_ready = 1'b1;
        flush_log();
        for (int f = 0; f < 5; f++) send_frame(64'h3, 1'b1);
        idle(4);
        n_checks++; if (parity_err_cnt !== 2'd3) begin n_fail++; $display("FAIL sat_pcnt got %0d exp 3", parity_err_cnt); end
        n_checks++; if (got_q.size() != 5) begin n_fail++; $display("FAIL sat_count got %0d exp 5", got_q.size()); end
        // Clear coincides with the sixth frame's stop-sample update edge.
        fork
            send_frame(64'h3, 1'b1);
            begin
                @(posedge clk);
                repeat (264) @(posedge clk);
                #1 clear_counts = 1'b1;
                @(posedge clk);
                #1 clear_counts = 1'b0;
                n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL clr_frame_valid got %b exp 1", rx_valid); end
            end
        join
        idle(4);
        n_checks++; if (parity_err_cnt !== 2'd0) begin n_fail++; $display("FAIL clr_wins got %0d exp 0", parity_err_cnt); end
        n_checks++; if (got_q.size() != 6) begin n_fail++; $display("FAIL clr_frame_count got %0d exp 6", got_q.size()); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout got running exp finished");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_single();
        test_parity();
        test_overflow();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
